// File: rtl/approx_err_acc.sv
// Error-metric accumulator for approximate 8x8 multipliers: sums, maxes and counts
// the error distance |approx - a*b| over a run of N_SAMPLES accepted samples.
module approx_err_acc #(
  parameter int N_SAMPLES = 65536,
  parameter int CNT_W     = 17,
  parameter int SUM_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [15:0]      prod_approx,
  output logic [SUM_W-1:0] sum_ed,
  output logic [15:0]      max_ed,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             r_s1_valid;
  logic [7:0]       r_s1_a;
  logic [7:0]       r_s1_b;
  logic [15:0]      r_s1_prod;
  logic             r_s2_valid;
  logic [15:0]      r_s2_ed;

  logic [SUM_W-1:0] r_sum;
  logic [15:0]      r_max;
  logic [CNT_W-1:0] r_err;

  logic             w_accept;
  logic             w_start_run;
  logic [15:0]      w_exact;
  logic [15:0]      w_ed;
  logic [SUM_W:0]   w_sum_ext;

  assign in_ready    = (r_state == RUN);
  assign w_accept    = in_valid && in_ready;
  assign w_start_run = start && ((r_state == IDLE) || (r_state == DONE));

  // Magnitude of the 17-bit signed difference, taken by ordering the operands.
  assign w_exact = 16'(r_s1_a) * 16'(r_s1_b);
  assign w_ed    = (r_s1_prod >= w_exact) ? (r_s1_prod - w_exact) : (w_exact - r_s1_prod);

  // One spare bit catches the carry-out that triggers saturation.
  assign w_sum_ext = {1'b0, r_sum} + {{(SUM_W-15){1'b0}}, r_s2_ed};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_start_run) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_IDX) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!r_s1_valid && !r_s2_valid) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_prod  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_ed    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a    <= a;
        r_s1_b    <= b;
        r_s1_prod <= prod_approx;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_ed <= w_ed;
      end
    end
  end

  // The pipeline is always empty in IDLE/DONE, so a start-clear never races an update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
      r_max <= '0;
      r_err <= '0;
    end else if (w_start_run) begin
      r_sum <= '0;
      r_max <= '0;
      r_err <= '0;
    end else if (r_s2_valid) begin
      r_sum <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
      if (r_s2_ed > r_max) begin
        r_max <= r_s2_ed;
      end
      if (r_s2_ed != 16'd0) begin
        r_err <= r_err + 1'b1;
      end
    end
  end

  assign sum_ed  = r_sum;
  assign max_ed  = r_max;
  assign err_cnt = r_err;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_approx_err_acc.sv
// Directed bench for approx_err_acc: three instances cover N_SAMPLES=4, N_SAMPLES=3
// and a 16-bit saturating accumulator; they share the sample bus.
module tb_approx_err_acc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] prod;

  logic        rst4, start4, ready4, busy4, done4;
  logic [31:0] sum4;
  logic [15:0] max4;
  logic [16:0] cnt4;

  logic        rst3, start3, ready3, busy3, done3;
  logic [31:0] sum3;
  logic [15:0] max3;
  logic [16:0] cnt3;

  logic        rst2, start2, ready2, busy2, done2;
  logic [15:0] sum2;
  logic [15:0] max2;
  logic [16:0] cnt2;

  int checks = 0;
  int errors = 0;

  approx_err_acc #(.N_SAMPLES(4)) u_dut4 (
    .clk(clk), .rst(rst4), .start(start4), .in_valid(in_valid), .in_ready(ready4),
    .a(a), .b(b), .prod_approx(prod), .sum_ed(sum4), .max_ed(max4), .err_cnt(cnt4),
    .busy(busy4), .done(done4)
  );

  approx_err_acc #(.N_SAMPLES(3)) u_dut3 (
    .clk(clk), .rst(rst3), .start(start3), .in_valid(in_valid), .in_ready(ready3),
    .a(a), .b(b), .prod_approx(prod), .sum_ed(sum3), .max_ed(max3), .err_cnt(cnt3),
    .busy(busy3), .done(done3)
  );

  approx_err_acc #(.N_SAMPLES(2), .SUM_W(16)) u_dut2 (
    .clk(clk), .rst(rst2), .start(start2), .in_valid(in_valid), .in_ready(ready2),
    .a(a), .b(b), .prod_approx(prod), .sum_ed(sum2), .max_ed(max2), .err_cnt(cnt2),
    .busy(busy2), .done(done2)
  );

  typedef struct {
    logic        v;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        ready;
    logic [31:0] sum;
    logic [15:0] mx;
    logic [16:0] cnt;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                               input logic [15:0] ip);
    in_valid = v;
    a        = ia;
    b        = ib;
    prod     = ip;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic doneOf(input int which);
    case (which)
      4:       return done4;
      3:       return done3;
      default: return done2;
    endcase
  endfunction

  // Bounded wait for done; returns the number of edges it took.
  task automatic waitDone(input int which, input string name, output int cycles);
    cycles = 0;
    while (!doneOf(which) && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput(name, doneOf(which), 1);
  endtask

  vec_t t3[3];
  vec_t t4[7];
  int   cyc;

  initial begin
    t3[0] = '{1'b1, 8'd255, 8'd255, 16'hFE00, 1'b1, 32'd1,  16'd1,  17'd1};
    t3[1] = '{1'b1, 8'd10,  8'd10,  16'd110,  1'b1, 32'd11, 16'd10, 17'd2};
    t3[2] = '{1'b1, 8'd12,  8'd12,  16'd144,  1'b1, 32'd11, 16'd10, 17'd2};

    t4[0] = '{1'b1, 8'd2,   8'd3,   16'd7,    1'b1, 32'd0, 16'd0, 17'd0};
    t4[1] = '{1'b0, 8'd9,   8'd9,   16'd0,    1'b1, 32'd0, 16'd0, 17'd0};
    t4[2] = '{1'b0, 8'd9,   8'd9,   16'd0,    1'b1, 32'd0, 16'd0, 17'd0};
    t4[3] = '{1'b1, 8'd100, 8'd100, 16'd9000, 1'b1, 32'd0, 16'd0, 17'd0};
    t4[4] = '{1'b0, 8'd9,   8'd9,   16'd0,    1'b1, 32'd0, 16'd0, 17'd0};
    t4[5] = '{1'b1, 8'd4,   8'd4,   16'd20,   1'b1, 32'd0, 16'd0, 17'd0};
    t4[6] = '{1'b1, 8'd1,   8'd1,   16'd500,  1'b0, 32'd0, 16'd0, 17'd0};

    rst4 = 1'b1; rst3 = 1'b1; rst2 = 1'b1;
    start4 = 1'b0; start3 = 1'b0; start2 = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, 16'd0);
    tick();
    tick();
    rst4 = 1'b0; rst3 = 1'b0; rst2 = 1'b0;

    // Idle with in_valid held high: nothing is accepted.
    applyStimulus(1'b1, 8'd255, 8'd255, 16'd0);
    repeat (5) tick();
    checkOutput("idle_ready4", ready4, 0);
    checkOutput("idle_busy4", busy4, 0);
    checkOutput("idle_done4", done4, 0);
    checkOutput("idle_sum4", sum4, 0);
    checkOutput("idle_max4", max4, 0);
    checkOutput("idle_cnt4", cnt4, 0);
    checkOutput("idle_ready3", ready3, 0);
    checkOutput("idle_ready2", ready2, 0);
    applyStimulus(1'b0, 8'd0, 8'd0, 16'd0);

    // Exact samples back to back; done must rise 3 edges after the last acceptance.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checkOutput("run_busy4", busy4, 1);
    checkOutput("run_ready4", ready4, 1);
    applyStimulus(1'b1, 8'd3, 8'd5, 16'd15);      tick();
    applyStimulus(1'b1, 8'd255, 8'd255, 16'd65025); tick();
    applyStimulus(1'b1, 8'd0, 8'd7, 16'd0);       tick();
    applyStimulus(1'b1, 8'd16, 8'd16, 16'd256);   tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 16'd0);
    checkOutput("drain_ready4", ready4, 0);
    waitDone(4, "exact_done4", cyc);
    checkOutput("exact_done_latency", cyc, 3);
    checkOutput("exact_sum4", sum4, 0);
    checkOutput("exact_max4", max4, 0);
    checkOutput("exact_cnt4", cnt4, 0);
    checkOutput("exact_busy4", busy4, 0);

    // Erroneous samples, spaced so each one's effect is visible on its own.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(t3[i].v, t3[i].a, t3[i].b, t3[i].p);
      tick();
      applyStimulus(1'b0, 8'd0, 8'd0, 16'd0);
      repeat (3) tick();
      checkOutput($sformatf("err_sum3[%0d]", i), sum3, t3[i].sum);
      checkOutput($sformatf("err_max3[%0d]", i), max3, t3[i].mx);
      checkOutput($sformatf("err_cnt3[%0d]", i), cnt3, t3[i].cnt);
    end
    checkOutput("err_done3", done3, 1);

    // Restart from DONE, then gappy in_valid plus one extra sample during DRAIN.
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    checkOutput("restart_sum3", sum3, 0);
    checkOutput("restart_max3", max3, 0);
    checkOutput("restart_cnt3", cnt3, 0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(t4[i].v, t4[i].a, t4[i].b, t4[i].p);
      checkOutput($sformatf("gap_ready3[%0d]", i), ready3, t4[i].ready);
      tick();
    end
    applyStimulus(1'b0, 8'd0, 8'd0, 16'd0);
    waitDone(3, "gap_done3", cyc);
    checkOutput("gap_sum3", sum3, 1005);
    checkOutput("gap_max3", max3, 1000);
    checkOutput("gap_cnt3", cnt3, 3);
    repeat (4) tick();
    checkOutput("hold_sum3", sum3, 1005);
    checkOutput("hold_done3", done3, 1);

    // 16-bit accumulator saturates and sticks.
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    applyStimulus(1'b1, 8'd255, 8'd255, 16'd0); tick();
    applyStimulus(1'b1, 8'd255, 8'd255, 16'd0); tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 16'd0);
    waitDone(2, "sat_done2", cyc);
    checkOutput("sat_sum2", sum2, 16'hFFFF);
    checkOutput("sat_max2", max2, 65025);
    checkOutput("sat_cnt2", cnt2, 2);

    // start during RUN is ignored; start in DONE clears; reset aborts a run.
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    applyStimulus(1'b1, 8'd2, 8'd2, 16'd5);
    tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 16'd0);
    repeat (3) tick();
    checkOutput("mid_sum4", sum4, 1);
    start4 = 1'b1;
    applyStimulus(1'b1, 8'd3, 8'd3, 16'd0);
    tick();
    start4 = 1'b0;
    applyStimulus(1'b0, 8'd0, 8'd0, 16'd0);
    repeat (3) tick();
    checkOutput("ignstart_sum4", sum4, 10);
    checkOutput("ignstart_max4", max4, 9);
    checkOutput("ignstart_cnt4", cnt4, 2);
    checkOutput("ignstart_busy4", busy4, 1);
    applyStimulus(1'b1, 8'd0, 8'd0, 16'd0);  tick();
    applyStimulus(1'b1, 8'd7, 8'd7, 16'd50); tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 16'd0);
    waitDone(4, "run2_done4", cyc);
    checkOutput("run2_sum4", sum4, 11);
    checkOutput("run2_max4", max4, 9);
    checkOutput("run2_cnt4", cnt4, 3);

    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    checkOutput("donestart_sum4", sum4, 0);
    checkOutput("donestart_max4", max4, 0);
    checkOutput("donestart_cnt4", cnt4, 0);
    checkOutput("donestart_busy4", busy4, 1);
    checkOutput("donestart_done4", done4, 0);
    applyStimulus(1'b1, 8'd5, 8'd5, 16'd30); tick();
    applyStimulus(1'b1, 8'd6, 8'd6, 16'd40); tick();
    applyStimulus(1'b0, 8'd0, 8'd0, 16'd0);
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    checkOutput("abort_sum4", sum4, 0);
    checkOutput("abort_max4", max4, 0);
    checkOutput("abort_cnt4", cnt4, 0);
    checkOutput("abort_busy4", busy4, 0);
    checkOutput("abort_done4", done4, 0);
    checkOutput("abort_ready4", ready4, 0);
    repeat (4) tick();
    checkOutput("flushed_sum4", sum4, 0);
    checkOutput("flushed_cnt4", cnt4, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
